// File: rtl/pndeser_pkg.sv
// Shared constants and state encoding for the serial packet deserializer.
package pndeser_pkg;

    localparam logic [3:0] HEADER = 4'b1101;
    localparam logic [3:0] FOOTER = 4'b0101;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_FOOT = 2'd3
    } state_t;

endpackage

// File: rtl/pnshift.sv
// Serial-in shift register: newest bit enters at bit 0, older bits move up.
// Clear has priority over shifting so a field can restart cleanly.
module pnshift #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    // Shift one bit per enabled cycle; reset and clear both empty the register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/pndeser.sv
// Serial packet deserializer: hunts for the header, captures the length and
// data fields, checks the footer, and presents the word on a valid/ack port.
// The header and footer matchers keep only the three previous bits; the
// fourth bit of each pattern is the live serial input, so the match is seen
// in the same cycle the last pattern bit arrives.
module pndeser
    import pndeser_pkg::*;
#(
    parameter int LW = 5,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          din_i,
    output logic [DW-1:0] dat_o,
    output logic [LW-1:0] len_o,
    output logic          vld_o,
    input  logic          ack_i,
    output logic          err_o,
    output logic          ovf_o
);

    state_t        state;
    logic [LW-1:0] cnt;
    logic [2:0]    win_q;
    logic [2:0]    foot_q;
    logic [LW-1:0] len_q;
    logic [DW-1:0] data_q;

    logic          hdr_hit;
    logic          frame_end;
    logic          foot_ok;
    logic          len_last;

    assign hdr_hit   = ({win_q, din_i} == HEADER);
    assign foot_ok   = ({foot_q, din_i} == FOOTER);
    assign frame_end = (state == ST_FOOT) && (cnt == '0);
    assign len_last  = (state == ST_LEN) && (cnt == '0);

    pnshift #(.W(3)) u_win (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (frame_end),
        .en    (state == ST_HUNT),
        .din   (din_i),
        .q     (win_q)
    );

    pnshift #(.W(LW)) u_len (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (1'b0),
        .en    (state == ST_LEN),
        .din   (din_i),
        .q     (len_q)
    );

    pnshift #(.W(DW)) u_data (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (len_last),
        .en    (state == ST_DATA),
        .din   (din_i),
        .q     (data_q)
    );

    pnshift #(.W(3)) u_foot (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (1'b0),
        .en    (state == ST_FOOT),
        .din   (din_i),
        .q     (foot_q)
    );

    // Frame sequencer: the counter is reloaded on entry to every field and only counts down within it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_HUNT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (hdr_hit) begin
                        state <= ST_LEN;
                        cnt   <= LW'(LW - 1);
                    end
                end
                ST_LEN: begin
                    if (cnt == '0) begin
                        state <= ST_DATA;
                        cnt   <= {len_q[LW-2:0], din_i};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        state <= ST_FOOT;
                        cnt   <= LW'(3);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FOOT: begin
                    if (cnt == '0) begin
                        state <= ST_HUNT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_HUNT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output word holder: a good frame loads only if the slot is free or being acked this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o <= '0;
            len_o <= '0;
            vld_o <= 1'b0;
            err_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            ovf_o <= 1'b0;
            if (vld_o && ack_i) begin
                vld_o <= 1'b0;
            end
            if (frame_end) begin
                if (foot_ok) begin
                    if (!vld_o || ack_i) begin
                        dat_o <= data_q;
                        len_o <= len_q;
                        vld_o <= 1'b1;
                    end else begin
                        ovf_o <= 1'b1;
                    end
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pndeser.sv
// Directed bench for pndeser: frames are serialised bit by bit, the expected
// outcome of each frame is queued when it is sent and compared when it ends.
module tb_pndeser;
    import pndeser_pkg::*;

    localparam int LW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          din_i = 1'b0;
    logic          ack_i = 1'b0;
    logic [DW-1:0] dat_o;
    logic [LW-1:0] len_o;
    logic          vld_o;
    logic          err_o;
    logic          ovf_o;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic [LW-1:0] len;
        logic          err;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    logic          m_vld = 1'b0;
    logic [DW-1:0] m_dat = '0;
    logic [LW-1:0] m_len = '0;

    pndeser #(.LW(LW), .DW(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din_i (din_i),
        .dat_o (dat_o),
        .len_o (len_o),
        .vld_o (vld_o),
        .ack_i (ack_i),
        .err_o (err_o),
        .ovf_o (ovf_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One serial bit: drive away from the edge, then sample just after it.
    task automatic tick(input logic b);
        din_i = b;
        @(posedge clk_i);
        #1;
    endtask

    // Queue the expected result of a frame, then serialise it onto din_i.
    task automatic applyStimulus(input logic [LW-1:0] len, input logic [DW-1:0] data,
                                 input logic [3:0] foot, input logic ack_last);
        exp_t        e;
        logic [63:0] mask;
        logic [3:0]  hdr;
        hdr   = HEADER;
        e.err = 1'b0;
        e.ovf = 1'b0;
        if (foot == FOOTER) begin
            if (!m_vld || ack_last) begin
                mask  = (64'd1 << (int'(len) + 1)) - 64'd1;
                m_vld = 1'b1;
                m_dat = data & mask[DW-1:0];
                m_len = len;
            end else begin
                e.ovf = 1'b1;
            end
        end else begin
            e.err = 1'b1;
        end
        e.vld = m_vld;
        e.dat = m_dat;
        e.len = m_len;
        sb.push_back(e);
        for (int i = 3; i >= 0; i--) tick(hdr[i]);
        for (int i = LW - 1; i >= 0; i--) tick(len[i]);
        for (int i = int'(len); i >= 0; i--) tick(data[i]);
        for (int i = 3; i >= 1; i--) tick(foot[i]);
        ack_i = ack_last;
        tick(foot[0]);
        ack_i = 1'b0;
    endtask

    // Compare the outputs seen right after a frame's last bit with the queued result.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.sb: observed empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".vld"}, DW'(vld_o), DW'(e.vld));
            chk({tag, ".dat"}, dat_o, e.dat);
            chk({tag, ".len"}, DW'(len_o), DW'(e.len));
            chk({tag, ".err"}, DW'(err_o), DW'(e.err));
            chk({tag, ".ovf"}, DW'(ovf_o), DW'(e.ovf));
        end
    endtask

    // Idle cycle with optional ack: pulses must have dropped, ack frees the slot.
    task automatic idleCheck(input string tag, input logic ack);
        ack_i = ack;
        tick(1'b0);
        ack_i = 1'b0;
        if (ack) m_vld = 1'b0;
        chk({tag, ".vld"}, DW'(vld_o), DW'(m_vld));
        chk({tag, ".err"}, DW'(err_o), '0);
        chk({tag, ".ovf"}, DW'(ovf_o), '0);
    endtask

    // Directed sequence.
    initial begin
        logic [11:0] part;
        $display("[TB] start");

        rst_i = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("rst.vld", DW'(vld_o), '0);
        chk("rst.dat", dat_o, '0);
        chk("rst.len", DW'(len_o), '0);
        chk("rst.err", DW'(err_o), '0);
        chk("rst.ovf", DW'(ovf_o), '0);
        rst_i = 1'b0;

        // Basic frame after idle zeros.
        for (int i = 0; i < 3; i++) tick(1'b0);
        applyStimulus(5'd7, 32'h0000_00B5, 4'b0101, 1'b0);
        checkOutput("t1");
        idleCheck("t1.ack", 1'b1);

        // Bad footer.
        applyStimulus(5'd7, 32'h0000_00B5, 4'b0111, 1'b0);
        checkOutput("t2");
        idleCheck("t2.post", 1'b1);

        // Back-to-back good frames with no ack: second is dropped.
        applyStimulus(5'd7, 32'h0000_005A, 4'b0101, 1'b0);
        checkOutput("t3a");
        applyStimulus(5'd3, 32'h0000_000C, 4'b0101, 1'b0);
        checkOutput("t3b");
        idleCheck("t3.post", 1'b0);

        // Ack on the completion cycle of a new frame: new word replaces old.
        applyStimulus(5'd15, 32'h0000_9C3E, 4'b0101, 1'b1);
        checkOutput("t4");
        idleCheck("t4.ack", 1'b1);

        // Full-width frame whose data contains header patterns.
        tick(1'b0);
        applyStimulus(5'd31, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        checkOutput("t5");

        // Reset in the middle of the data field, then a minimal frame.
        part = 12'b1101_00111_101;
        for (int i = 11; i >= 0; i--) tick(part[i]);
        rst_i = 1'b1;
        tick(1'b0);
        rst_i = 1'b0;
        m_vld = 1'b0;
        m_dat = '0;
        m_len = '0;
        chk("t6.rst.vld", DW'(vld_o), '0);
        chk("t6.rst.dat", dat_o, '0);
        chk("t6.rst.len", DW'(len_o), '0);
        applyStimulus(5'd0, 32'h0000_0001, 4'b0101, 1'b0);
        checkOutput("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
